// File: rtl/map_port_arbiter.sv
// Single-port map BRAM arbiter: eat read-modify-write has priority over
// round-robin Pac-Man/ghost reads, and a pellet counter tracks level completion.
module map_port_arbiter #(
  parameter int         ADDR_W       = 11,
  parameter int         DEPTH        = 1152,
  parameter logic [3:0] TILE_EMPTY   = 4'h0,
  parameter logic [3:0] TILE_PELLET  = 4'h1,
  parameter logic [3:0] TILE_POWER   = 4'h2,
  parameter logic [3:0] OOR_TILE     = 4'hF,
  parameter int         PELLET_TOTAL = 244
) (
  input  logic              vga_pix_clk,
  input  logic              rst,
  input  logic              pac_rd_req,
  input  logic [ADDR_W-1:0] pac_rd_addr,
  output logic              pac_rd_gnt,
  output logic              pac_rd_valid,
  output logic [3:0]        pac_rd_data,
  input  logic              gh_rd_req,
  input  logic [ADDR_W-1:0] gh_rd_addr,
  output logic              gh_rd_gnt,
  output logic              gh_rd_valid,
  output logic [3:0]        gh_rd_data,
  input  logic              eat_req,
  input  logic [ADDR_W-1:0] eat_addr,
  output logic              eat_gnt,
  output logic              eat_busy,
  output logic              eat_done,
  output logic [1:0]        eaten_kind,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_di,
  input  logic [3:0]        mem_dout,
  output logic [7:0]        pellets_left,
  output logic              level_clear
);

  typedef enum logic {IDLE, EAT_CHK} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0] K_NONE = 2'b00, K_PELLET = 2'b01, K_POWER = 2'b10;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;          // 1: ghost wins the next tie
  logic [ADDR_W-1:0] eat_addr_q, eat_addr_d;
  logic              eat_oor_q, eat_oor_d;
  logic              pac_vld_q, pac_oor_q, gh_vld_q, gh_oor_q;
  logic              done_q;
  logic [1:0]        kind_q, kind;
  logic [7:0]        pellets_q;
  logic              lc_q;
  logic              pac_oor, gh_oor, eat_oor;

  assign pac_oor = {1'b0, pac_rd_addr} >= DEPTH_C;
  assign gh_oor  = {1'b0, gh_rd_addr}  >= DEPTH_C;
  assign eat_oor = {1'b0, eat_addr}    >= DEPTH_C;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    eat_addr_d = eat_addr_q;
    eat_oor_d  = eat_oor_q;
    pac_rd_gnt = 1'b0;
    gh_rd_gnt  = 1'b0;
    eat_gnt    = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    kind       = K_NONE;
    case (state_q)
      IDLE: begin
        if (eat_req) begin
          eat_gnt    = 1'b1;
          mem_addr   = eat_oor ? '0 : eat_addr;
          eat_addr_d = eat_addr;
          eat_oor_d  = eat_oor;
          state_d    = EAT_CHK;
        end else if (pac_rd_req && (!gh_rd_req || !rr_q)) begin
          pac_rd_gnt = 1'b1;
          mem_addr   = pac_oor ? '0 : pac_rd_addr;
          rr_d       = 1'b1;
        end else if (gh_rd_req) begin
          gh_rd_gnt  = 1'b1;
          mem_addr   = gh_oor ? '0 : gh_rd_addr;
          rr_d       = 1'b0;
        end
      end
      EAT_CHK: begin
        state_d = IDLE;
        if (!eat_oor_q) begin
          if (mem_dout == TILE_PELLET)     kind = K_PELLET;
          else if (mem_dout == TILE_POWER) kind = K_POWER;
        end
        if (kind != K_NONE) begin
          mem_we   = 1'b1;
          mem_addr = eat_addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over everything, including a write pending in EAT_CHK.
    if (rst) begin
      pac_rd_gnt = 1'b0;
      gh_rd_gnt  = 1'b0;
      eat_gnt    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      eat_addr_q <= '0;
      eat_oor_q  <= 1'b0;
      pac_vld_q  <= 1'b0;
      pac_oor_q  <= 1'b0;
      gh_vld_q   <= 1'b0;
      gh_oor_q   <= 1'b0;
      done_q     <= 1'b0;
      kind_q     <= K_NONE;
      pellets_q  <= 8'(PELLET_TOTAL);
      lc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      eat_addr_q <= eat_addr_d;
      eat_oor_q  <= eat_oor_d;
      pac_vld_q  <= pac_rd_gnt;
      pac_oor_q  <= pac_oor;
      gh_vld_q   <= gh_rd_gnt;
      gh_oor_q   <= gh_oor;
      done_q     <= (state_q == EAT_CHK);
      kind_q     <= kind;
      if (kind != K_NONE && pellets_q != 8'd0) pellets_q <= pellets_q - 8'd1;
      lc_q       <= (pellets_q == 8'd0);
    end
  end

  assign eat_busy     = (state_q == EAT_CHK);
  assign eat_done     = done_q;
  assign eaten_kind   = done_q ? kind_q : K_NONE;
  assign mem_di       = TILE_EMPTY;
  assign pac_rd_valid = pac_vld_q;
  assign gh_rd_valid  = gh_vld_q;
  assign pac_rd_data  = pac_vld_q ? (pac_oor_q ? OOR_TILE : mem_dout) : 4'h0;
  assign gh_rd_data   = gh_vld_q  ? (gh_oor_q  ? OOR_TILE : mem_dout) : 4'h0;
  assign pellets_left = pellets_q;
  assign level_clear  = lc_q;

endmodule
